// File: rtl/z80_bus_arbiter_pkg.sv
// Shared types and defaults for the Z80 memory-port arbiter.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int DEF_GAP_CYCLES = 8;
  localparam int DEF_MAX_HOLD   = 100;

endpackage

// File: rtl/z80_bus_arbiter_if.sv
// CPU / DMA / memory signal bundle seen by the arbiter; master is the arbiter side.
interface z80_bus_arbiter_if;

  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n;
  logic        cpu_wr_n;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] dma_a;
  logic [7:0]  dma_do;
  logic        dma_wr;
  logic [15:0] mem_a;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_owner;
  logic        hold_err;

  modport master (
    output cpu_busrq_n, dma_gnt, mem_a, mem_wdata, mem_we, mem_owner, hold_err,
    input  cpu_busak_n, cpu_a, cpu_do, cpu_mreq_n, cpu_wr_n,
    input  dma_req, dma_a, dma_do, dma_wr
  );

  modport slave (
    input  cpu_busrq_n, dma_gnt, mem_a, mem_wdata, mem_we, mem_owner, hold_err,
    output cpu_busak_n, cpu_a, cpu_do, cpu_mreq_n, cpu_wr_n,
    output dma_req, dma_a, dma_do, dma_wr
  );

endinterface

// File: rtl/z80_bus_arbiter_mux.sv
// Combinational owner select for the shared memory port.
module z80_bus_mux
  import z80_bus_pkg::*;
(
  input  logic        owner,
  input  logic        gnt,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_do,
  input  logic        dma_wr,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_wdata,
  output logic        mem_we
);

  // DMA writes are gated by the grant so the RELEASE drain never writes.
  assign mem_a     = (owner == OWNER_DMA) ? dma_a  : cpu_a;
  assign mem_wdata = (owner == OWNER_DMA) ? dma_do : cpu_do;
  assign mem_we    = (owner == OWNER_DMA) ? (dma_wr & gnt) : (~cpu_mreq_n & ~cpu_wr_n);

endmodule

// File: rtl/z80_bus_arbiter.sv
// BUSRQ/BUSAK sequencer sharing the memory port between the CPU and one DMA master.
// Optional tenure limit enabled by defining HOLD_LIMIT_EN.
module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input logic               clk,
  input logic               reset_n,
  z80_bus_arbiter_if.master bus
);

  localparam int GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  arb_state_t    state;
  logic          busrq_n;
  logic          gnt;
  logic          owner;
  logic [GW-1:0] gap;
  logic          req_ok;

`ifdef HOLD_LIMIT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] hold;
  logic          hold_err;
  logic          need_drop;

  // After a forced release the DMA must drop its request before asking again.
  assign req_ok       = bus.dma_req & ~need_drop;
  assign bus.hold_err = hold_err;
`else
  assign req_ok       = bus.dma_req;
  assign bus.hold_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busrq_n <= 1'b1;
      gnt     <= 1'b0;
      owner   <= OWNER_CPU;
      gap     <= '0;
`ifdef HOLD_LIMIT_EN
      hold      <= '0;
      hold_err  <= 1'b0;
      need_drop <= 1'b0;
`endif
    end else begin
`ifdef HOLD_LIMIT_EN
      if (!bus.dma_req) need_drop <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_ok && gap == '0) begin
            state   <= REQ;
            busrq_n <= 1'b0;
          end else if (gap != '0) begin
            gap <= gap - 1'b1;
          end
        end
        REQ: begin
          if (!bus.cpu_busak_n) begin
            state <= GRANT;
            gnt   <= 1'b1;
            owner <= OWNER_DMA;
          end else if (!bus.dma_req) begin
            state   <= RELEASE;
            busrq_n <= 1'b1;
          end
        end
        // BUSAK glitches while granted are deliberately ignored.
        GRANT: begin
          if (!bus.dma_req) begin
            state   <= RELEASE;
            gnt     <= 1'b0;
            busrq_n <= 1'b1;
          end
`ifdef HOLD_LIMIT_EN
          else if (hold == HW'(MAX_HOLD - 1)) begin
            state     <= RELEASE;
            gnt       <= 1'b0;
            busrq_n   <= 1'b1;
            hold_err  <= 1'b1;
            need_drop <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (bus.cpu_busak_n) begin
            state <= IDLE;
            owner <= OWNER_CPU;
            gap   <= GW'(GAP_LOAD);
`ifdef HOLD_LIMIT_EN
            hold  <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_busrq_n = busrq_n;
  assign bus.dma_gnt     = gnt;
  assign bus.mem_owner   = owner;

  z80_bus_mux u_mux (
    .owner      (owner),
    .gnt        (gnt),
    .cpu_a      (bus.cpu_a),
    .cpu_do     (bus.cpu_do),
    .cpu_mreq_n (bus.cpu_mreq_n),
    .cpu_wr_n   (bus.cpu_wr_n),
    .dma_a      (bus.dma_a),
    .dma_do     (bus.dma_do),
    .dma_wr     (bus.dma_wr),
    .mem_a      (bus.mem_a),
    .mem_wdata  (bus.mem_wdata),
    .mem_we     (bus.mem_we)
  );

endmodule
